ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and initialisation sequencer for the single-clock simple dual-port RAM (one write port, one registered read port, 1-cycle read latency, no reset on contents). After reset it zero-fills every RAM word. It then grants at most one access per cycle to requester A or B and routes each read result back to the requester that issued the read. It sits between two client blocks and one RAM instance, and drives all RAM ports.

---
 rtl/ram_arbiter.sv | 116 +++++++++++
 tb/tb_ram_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two clients sharing one simple dual-port RAM.
// After reset it zero-fills the RAM, then grants one access per cycle and routes read data to its owner.
module ram_arbiter #(
   parameter  int DWIDTH = 16,
   parameter  int DEPTH  = 256,
   localparam int AWIDTH = $clog2(DEPTH)
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              a_req_valid,
   input  logic              a_req_we,
   input  logic [AWIDTH-1:0] a_req_addr,
   input  logic [DWIDTH-1:0] a_req_data,
   output logic              a_req_ready,
   output logic              a_rsp_valid,
   output logic [DWIDTH-1:0] a_rsp_data,
   input  logic              b_req_valid,
   input  logic              b_req_we,
   input  logic [AWIDTH-1:0] b_req_addr,
   input  logic [DWIDTH-1:0] b_req_data,
   output logic              b_req_ready,
   output logic              b_rsp_valid,
   output logic [DWIDTH-1:0] b_rsp_data,
   output logic              ram_we,
   output logic [AWIDTH-1:0] ram_wr_addr,
   output logic [AWIDTH-1:0] ram_rd_addr,
   output logic [DWIDTH-1:0] ram_din,
   input  logic [DWIDTH-1:0] ram_dout,
   output logic              init_done
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state;
   logic [AWIDTH-1:0] cnt;
   logic              ptr_b;     // 0: A has priority on contention, 1: B
   logic              pend_a;
   logic              pend_b;
   logic              run;
   logic              a_gnt;
   logic              b_gnt;

   assign run   = (state == S_RUN) && !areset;
   assign a_gnt = run && a_req_valid && (!b_req_valid || !ptr_b);
   assign b_gnt = run && b_req_valid && (!a_req_valid ||  ptr_b);

   assign a_req_ready = a_gnt;
   assign b_req_ready = b_gnt;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state     <= S_INIT;
         cnt       <= '0;
         ptr_b     <= 1'b0;
         pend_a    <= 1'b0;
         pend_b    <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               pend_a <= 1'b0;
               pend_b <= 1'b0;
               // counter parks at the last address so it never wraps into RUN
               if (cnt == AWIDTH'(DEPTH - 1)) begin
                  state     <= S_RUN;
                  init_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (a_gnt)      ptr_b <= 1'b1;
               else if (b_gnt) ptr_b <= 1'b0;
               pend_a <= a_gnt && !a_req_we;
               pend_b <= b_gnt && !b_req_we;
            end
         endcase
      end
   end

   always_comb begin
      ram_we      = 1'b0;
      ram_wr_addr = '0;
      ram_rd_addr = '0;
      ram_din     = '0;
      if (!areset) begin
         if (state == S_INIT) begin
            ram_we      = 1'b1;
            ram_wr_addr = cnt;
         end else if (a_gnt) begin
            ram_we = a_req_we;
            if (a_req_we) begin
               ram_wr_addr = a_req_addr;
               ram_din     = a_req_data;
            end else begin
               ram_rd_addr = a_req_addr;
            end
         end else if (b_gnt) begin
            ram_we = b_req_we;
            if (b_req_we) begin
               ram_wr_addr = b_req_addr;
               ram_din     = b_req_data;
            end else begin
               ram_rd_addr = b_req_addr;
            end
         end
      end
   end

   // read data is steered only to the client that issued the read
   assign a_rsp_valid = pend_a;
   assign b_rsp_valid = pend_b;
   assign a_rsp_data  = pend_a ? ram_dout : '0;
   assign b_rsp_data  = pend_b ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a response scoreboard.
module tb_ram_arbiter;

   localparam int DW = 16;
   localparam int DEPTH = 256;
   localparam int AW = 8;

   logic          aclk = 1'b0;
   logic          areset;
   logic          a_req_valid, a_req_we, b_req_valid, b_req_we;
   logic [AW-1:0] a_req_addr, b_req_addr;
   logic [DW-1:0] a_req_data, b_req_data;
   logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
   logic [DW-1:0] a_rsp_data, b_rsp_data;
   logic          ram_we, init_done;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;
   logic [DW-1:0] ram_din, ram_dout;

   typedef struct {
      bit            owner_b;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] shadow[DEPTH];
   logic [DW-1:0] mem[DEPTH];
   int            n_assert = 0;
   int            n_fail   = 0;

   always #5 aclk = ~aclk;

   ram_arbiter #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
      .aclk(aclk), .areset(areset),
      .a_req_valid(a_req_valid), .a_req_we(a_req_we), .a_req_addr(a_req_addr),
      .a_req_data(a_req_data), .a_req_ready(a_req_ready),
      .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
      .b_req_valid(b_req_valid), .b_req_we(b_req_we), .b_req_addr(b_req_addr),
      .b_req_data(b_req_data), .b_req_ready(b_req_ready),
      .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
      .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
      .ram_din(ram_din), .ram_dout(ram_dout), .init_done(init_done)
   );

   // behavioural simple dual-port RAM, 1-cycle registered read
   always @(posedge aclk) begin
      if (ram_we) mem[ram_wr_addr] <= ram_din;
      ram_dout <= mem[ram_rd_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // response monitor: every rsp_valid must match the oldest expected read
   always @(negedge aclk) begin
      if (!areset) begin
         if (a_rsp_valid || b_rsp_valid) begin
            chk("rsp_one_hot", {31'd0, a_rsp_valid && b_rsp_valid}, 32'd0);
            chk("rsp_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_owner_b", {31'd0, b_rsp_valid}, {31'd0, e.owner_b});
               chk("rsp_data", e.owner_b ? b_rsp_data : a_rsp_data, e.data);
               chk("rsp_other_data", e.owner_b ? a_rsp_data : b_rsp_data, 0);
            end
         end else begin
            chk("rsp_idle_data", {a_rsp_data, b_rsp_data}, 0);
         end
      end
   end

   task automatic drive_a(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      a_req_valid = v; a_req_we = we; a_req_addr = ad; a_req_data = d;
   endtask

   task automatic drive_b(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      b_req_valid = v; b_req_we = we; b_req_addr = ad; b_req_data = d;
   endtask

   // bookkeeping for an expected grant: check RAM ports, then update model
   task automatic accept(input bit is_b);
      logic          we;
      logic [AW-1:0] ad;
      logic [DW-1:0] d;
      we = is_b ? b_req_we : a_req_we;
      ad = is_b ? b_req_addr : a_req_addr;
      d  = is_b ? b_req_data : a_req_data;
      chk("ram_we", {31'd0, ram_we}, {31'd0, we});
      if (we) begin
         chk("ram_wr_addr", ram_wr_addr, ad);
         chk("ram_din", ram_din, d);
         shadow[ad] = d;
      end else begin
         chk("ram_rd_addr", ram_rd_addr, ad);
         sb.push_back('{owner_b: is_b, data: shadow[ad]});
      end
   endtask

   // called just after a negedge with inputs driven; ends at the next negedge
   task automatic cyc(input bit ea, input bit eb);
      #1;
      chk("a_req_ready", {31'd0, a_req_ready}, {31'd0, ea});
      chk("b_req_ready", {31'd0, b_req_ready}, {31'd0, eb});
      if (ea) accept(1'b0);
      if (eb) accept(1'b1);
      if (!ea && !eb) chk("idle_ram_ports", {ram_we, ram_wr_addr, ram_rd_addr, ram_din}, 0);
      @(negedge aclk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, a_rsp_data, b_rsp_data}, 0);
      chk(tag, {ram_we, ram_wr_addr, ram_rd_addr, ram_din, init_done}, 0);
   endtask

   task automatic run_init();
      for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
      for (int k = 0; k < DEPTH; k++) begin
         #1;
         chk("init_done_low", {31'd0, init_done}, 0);
         chk("init_we", {31'd0, ram_we}, 1);
         chk("init_addr", ram_wr_addr, k);
         chk("init_din", ram_din, 0);
         chk("init_ready", {a_req_ready, b_req_ready}, 0);
         @(negedge aclk);
      end
      #1;
      chk("init_done_high", {31'd0, init_done}, 1);
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);
      areset = 1'b1;
      drive_a(1, 0, 8'd3, 16'h0);
      drive_b(1, 1, 8'd4, 16'hFFFF);
      repeat (3) @(negedge aclk);
      chk_all_zero("reset_outputs");

      // B's read is offered during INIT and must wait for RUN
      drive_a(0, 0, 0, 0);
      drive_b(1, 0, 8'd200, 16'h0);
      areset = 1'b0;
      run_init();
      cyc(0, 1);
      drive_b(0, 0, 0, 0);

      drive_a(1, 1, 8'd5, 16'hBEEF); cyc(1, 0);
      drive_a(1, 0, 8'd5, 16'h0);    cyc(1, 0);
      drive_a(1, 1, 8'd9, 16'h1234); cyc(1, 0);
      drive_a(0, 0, 0, 0);
      drive_b(1, 0, 8'd9, 16'h0);    cyc(0, 1);
      drive_b(0, 0, 0, 0);
      repeat (3) cyc(0, 0);

      // contention: pointer rests on A after B's grant and idle cycles
      drive_a(1, 0, 8'd5, 16'h0);
      drive_b(1, 0, 8'd9, 16'h0);
      repeat (3) begin cyc(1, 0); cyc(0, 1); end
      drive_a(0, 0, 0, 0);
      drive_b(0, 0, 0, 0);
      repeat (2) cyc(0, 0);

      // write then a read that is killed by reset before its response
      drive_a(1, 1, 8'd7, 16'h5555); cyc(1, 0);
      drive_a(1, 0, 8'd7, 16'h0);
      #1;
      chk("kill_a_ready", {31'd0, a_req_ready}, 1);
      @(posedge aclk);
      #1 areset = 1'b1;
      sb.delete();
      drive_a(0, 0, 0, 0);
      #1;
      chk_all_zero("midop_reset");
      repeat (2) begin
         @(negedge aclk);
         chk_all_zero("reset_hold");
      end
      areset = 1'b0;
      run_init();

      // pointer back at A; both read the address written before reset
      drive_a(1, 0, 8'd7, 16'h0);
      drive_b(1, 0, 8'd7, 16'h0);
      cyc(1, 0);
      drive_a(0, 0, 0, 0);
      cyc(0, 1);
      drive_b(0, 0, 0, 0);
      repeat (3) cyc(0, 0);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
